// File: rtl/port_uart_pkg.sv
// Shared definitions for the port-bus UART: register map, status bits,
// FSM encodings and RX FIFO sizing.
package port_uart_pkg;

  // Register offsets from BASE
  localparam logic [7:0] OffData   = 8'd0;
  localparam logic [7:0] OffStatus = 8'd1;
  localparam logic [7:0] OffDivLo  = 8'd2;
  localparam logic [7:0] OffDivHi  = 8'd3;
  localparam logic [7:0] OffIrqEn  = 8'd4;

  // STATUS bit positions
  localparam int unsigned StTxReady  = 0;
  localparam int unsigned StTxBusy   = 1;
  localparam int unsigned StRxAvail  = 2;
  localparam int unsigned StRxFull   = 3;
  localparam int unsigned StOverrun  = 4;
  localparam int unsigned StFrameErr = 5;

  // RX FIFO geometry
  localparam int unsigned FifoDepth     = 4;
  localparam int unsigned FifoPtrW      = 2;
  localparam logic [2:0]  FifoFullCount = 3'd4;

  // Smallest usable bit-period divisor
  localparam logic [15:0] DivMin = 16'd3;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStartChk,
    RxData,
    RxStop
  } rx_state_e;

  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div < DivMin) ? DivMin : div;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// 4x8 receive FIFO. A pop in the same cycle as a push into a full FIFO frees
// the slot first, so the push is accepted.
module uart_rx_fifo
  import port_uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  logic [7:0]          mem_q [FifoDepth];
  logic [FifoPtrW-1:0] wr_ptr_q;
  logic [FifoPtrW-1:0] rd_ptr_q;
  logic [FifoPtrW:0]   count_q;
  logic                do_push;
  logic                do_pop;

  assign full    = (count_q == FifoFullCount);
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {2'b00, do_push} - {2'b00, do_pop};
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/port_uart.sv
// Port-bus UART: double-buffered 8N1 transmitter, mid-bit sampling receiver
// with a 4-entry FIFO, programmable divisor and a level interrupt.
module port_uart
  import port_uart_pkg::*;
#(
  parameter logic [7:0]  BASE      = 8'h10,
  parameter logic [15:0] DIV_RESET = 16'd103
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  output logic       irq,
  input  logic       rxd,
  output logic       txd
);

  // Bus decode
  logic [7:0] offset;
  logic       hit;
  logic       wr_data, wr_div_lo, wr_div_hi, wr_irq_en;
  logic       rd_data, rd_status;

  assign offset    = port_id - BASE;
  assign hit       = (offset <= OffIrqEn);
  assign wr_data   = write_strobe & hit & (offset == OffData);
  assign wr_div_lo = write_strobe & hit & (offset == OffDivLo);
  assign wr_div_hi = write_strobe & hit & (offset == OffDivHi);
  assign wr_irq_en = write_strobe & hit & (offset == OffIrqEn);
  assign rd_data   = read_strobe & hit & (offset == OffData);
  assign rd_status = read_strobe & hit & (offset == OffStatus);

  // Control registers
  logic [15:0] div_q;
  logic [7:0]  irq_en_q;
  logic [15:0] div_eff;
  logic [15:0] rx_half_m1;

  assign div_eff    = eff_div(div_q);
  // (div_eff + 1) / 2 - 1 without a carry bit
  assign rx_half_m1 = {1'b0, div_eff[15:1]} + {15'd0, div_eff[0]} - 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= DIV_RESET;
      irq_en_q <= 8'h00;
    end else begin
      if (wr_div_lo) div_q[7:0]  <= out_port;
      if (wr_div_hi) div_q[15:8] <= out_port;
      if (wr_irq_en) irq_en_q    <= out_port;
    end
  end

  // Transmitter
  tx_state_e   tx_state_q;
  logic [15:0] tx_cnt_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_shift_q;
  logic        hold_valid_q;
  logic [7:0]  hold_data_q;
  logic        tx_ready;
  logic        tx_busy;

  assign tx_ready = ~hold_valid_q;
  assign tx_busy  = (tx_state_q != TxIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q   <= TxIdle;
      txd          <= 1'b1;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      if (wr_data && !hold_valid_q) begin
        hold_valid_q <= 1'b1;
        hold_data_q  <= out_port;
      end
      unique case (tx_state_q)
        TxIdle: begin
          if (hold_valid_q) begin
            tx_state_q   <= TxStart;
            txd          <= 1'b0;
            tx_cnt_q     <= div_eff;
            tx_shift_q   <= hold_data_q;
            hold_valid_q <= 1'b0;
          end
        end
        TxStart: begin
          if (tx_cnt_q == '0) begin
            tx_state_q <= TxData;
            txd        <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_bit_q   <= '0;
            tx_cnt_q   <= div_eff;
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        TxData: begin
          if (tx_cnt_q == '0) begin
            tx_cnt_q <= div_eff;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= TxStop;
              txd        <= 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              txd        <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        TxStop: begin
          if (tx_cnt_q == '0) begin
            // Chain straight into the next start bit when a byte is waiting
            if (hold_valid_q) begin
              tx_state_q   <= TxStart;
              txd          <= 1'b0;
              tx_cnt_q     <= div_eff;
              tx_shift_q   <= hold_data_q;
              hold_valid_q <= 1'b0;
            end else begin
              tx_state_q <= TxIdle;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
      endcase
    end
  end

  // Receiver
  rx_state_e   rx_state_q;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;
  logic        rx_stop_now;
  logic        rx_push;
  logic        ferr_set;

  assign rx_stop_now = (rx_state_q == RxStop) && (rx_cnt_q == '0);
  assign rx_push     = rx_stop_now & rx_sync_q;
  assign ferr_set    = rx_stop_now & ~rx_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q <= rxd;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      unique case (rx_state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RxStartChk;
            rx_cnt_q   <= rx_half_m1;
          end
        end
        RxStartChk: begin
          if (rx_cnt_q == '0) begin
            if (rx_sync_q) begin
              rx_state_q <= RxIdle;
            end else begin
              rx_state_q <= RxData;
              rx_cnt_q   <= div_eff;
              rx_bit_q   <= '0;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        RxData: begin
          if (rx_cnt_q == '0) begin
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_cnt_q   <= div_eff;
            if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        RxStop: begin
          if (rx_cnt_q == '0) rx_state_q <= RxIdle;
          else                rx_cnt_q   <= rx_cnt_q - 16'd1;
        end
      endcase
    end
  end

  // RX FIFO
  logic [7:0] fifo_rdata;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       ovr_set;

  assign fifo_pop = rd_data & ~fifo_empty;
  assign ovr_set  = rx_push & fifo_full & ~fifo_pop;

  uart_rx_fifo u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (fifo_pop),
    .wdata (rx_shift_q),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky error flags; a new event beats a simultaneous clearing read
  logic overrun_q;
  logic frame_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq         <= 1'b0;
    end else begin
      overrun_q   <= ovr_set | (overrun_q & ~rd_status);
      frame_err_q <= ferr_set | (frame_err_q & ~rd_status);
      irq         <= (irq_en_q[0] & ~fifo_empty) | (irq_en_q[1] & tx_ready);
    end
  end

  // Read mux
  logic [7:0] status;

  always_comb begin
    status             = 8'h00;
    status[StTxReady]  = tx_ready;
    status[StTxBusy]   = tx_busy;
    status[StRxAvail]  = ~fifo_empty;
    status[StRxFull]   = fifo_full;
    status[StOverrun]  = overrun_q;
    status[StFrameErr] = frame_err_q;
  end

  always_comb begin
    in_port = 8'h00;
    if (hit) begin
      unique case (offset)
        OffData:   in_port = fifo_empty ? 8'h00 : fifo_rdata;
        OffStatus: in_port = status;
        OffDivLo:  in_port = div_q[7:0];
        OffDivHi:  in_port = div_q[15:8];
        OffIrqEn:  in_port = irq_en_q;
        default:   in_port = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_port_uart.sv
// Randomised self-checking bench for port_uart against a byte/queue-level model.
module tb_port_uart;

  localparam logic [7:0] Base = 8'h10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       irq;
  logic       rxd;
  logic       txd;

  always #5 clk = ~clk;

  port_uart #(
    .BASE      (Base),
    .DIV_RESET (16'd103)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .port_id      (port_id),
    .out_port     (out_port),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .in_port      (in_port),
    .irq          (irq),
    .rxd          (rxd),
    .txd          (txd)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // txd log, sampled 1ns after every rising edge
  int cyc = 0;
  bit txd_log [0:32767];
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc < 32768) txd_log[cyc] = txd;
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // Reference model
  logic [15:0] m_div;
  logic [7:0]  mq[$];
  bit          m_ovr;
  bit          m_ferr;

  function automatic int period();
    return ((m_div < 16'd3) ? 3 : int'(m_div)) + 1;
  endfunction

  function automatic logic [7:0] exp_status();
    return {2'b00, m_ferr, m_ovr, mq.size() == 4, mq.size() != 0, 1'b0, 1'b1};
  endfunction

  function automatic logic exp_txd(input int t, input logic [7:0] b, input int p);
    int bi;
    bi = t / p;
    if (bi == 0) return 1'b0;
    if (bi >= 9) return 1'b1;
    return b[bi-1];
  endfunction

  // Bus tasks: entered and left 1ns after a rising edge
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d, output int k);
    port_id      = Base + {5'd0, off};
    out_port     = d;
    write_strobe = 1'b1;
    @(posedge clk);
    #1;
    k            = cyc;
    write_strobe = 1'b0;
    port_id      = 8'h00;
  endtask

  task automatic rd(input logic [2:0] off, output logic [7:0] d);
    port_id     = Base + {5'd0, off};
    read_strobe = 1'b1;
    #1;
    d = in_port;
    @(posedge clk);
    #1;
    read_strobe = 1'b0;
    port_id     = 8'h00;
  endtask

  task automatic peek(input logic [7:0] a, output logic [7:0] d);
    port_id = a;
    #1;
    d       = in_port;
    port_id = 8'h00;
  endtask

  task automatic set_div(input logic [15:0] d);
    int k;
    wr(3'd2, d[7:0], k);
    wr(3'd3, d[15:8], k);
    m_div = d;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    int p;
    p   = period();
    rxd = 1'b0;
    idle(p);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(p);
    end
    rxd = stop;
    idle(p);
    rxd = 1'b1;
    if (stop) begin
      if (mq.size() == 4) m_ovr = 1'b1;
      else mq.push_back(b);
    end else begin
      m_ferr = 1'b1;
    end
    idle(p + 2);
  endtask

  task automatic rd_data_chk(input string tag);
    logic [7:0] v, e;
    rd(3'd0, v);
    e = (mq.size() != 0) ? mq.pop_front() : 8'h00;
    check(tag, v, e);
  endtask

  task automatic rd_status_chk(input string tag);
    logic [7:0] v;
    rd(3'd1, v);
    check(tag, v, exp_status());
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic frame_chk(input string tag, input int l, input logic [7:0] b, input int p);
    int bad;
    bad = 0;
    for (int t = 0; t < 10 * p; t++)
      if (txd_log[l + t] !== exp_txd(t, b, p)) bad++;
    check(tag, bad, 0);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] b;
    int         k, k1, busy, bad, p, s;
    bit         ok;

    port_id = 8'h00; out_port = 8'h00; write_strobe = 1'b0; read_strobe = 1'b0;
    rxd = 1'b1;
    m_div = 16'd103; m_ovr = 1'b0; m_ferr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Reset state
    check("rst_txd", txd, 1);
    check("rst_irq", irq, 0);
    check("rst_unaddr", in_port, 0);
    peek(Base + 8'd5, v); check("unaddr_hi", v, 0);
    peek(Base - 8'd1, v); check("unaddr_lo", v, 0);
    rd_status_chk("rst_status");
    rd(3'd2, v); check("rst_div_lo", v, 8'd103);
    rd(3'd3, v); check("rst_div_hi", v, 8'd0);
    rd(3'd4, v); check("rst_irq_en", v, 8'd0);

    // Single A5 frame at DIV=3
    set_div(16'd3);
    wr(3'd0, 8'hA5, k);
    peek(Base + 8'd1, v); check("tx_ready_k", v[1:0], 2'b00);
    idle(1);
    peek(Base + 8'd1, v); check("tx_k1", v[1:0], 2'b11);
    busy = 1;
    for (int i = 0; i < 45; i++) begin
      idle(1);
      peek(Base + 8'd1, v);
      if (v[1]) busy++;
    end
    check("tx_busy_len", busy, 40);
    frame_chk("tx_a5", k + 1, 8'hA5, 4);
    check("tx_idle_after", txd_log[k + 41], 1);

    // Random bytes with random divisors, including values below the minimum
    for (int n = 0; n < 4; n++) begin
      set_div(16'($urandom_range(0, 6)));
      p = period();
      b = 8'($urandom);
      wr(3'd0, b, k);
      idle(10 * p + 4);
      frame_chk($sformatf("tx_rand%0d", n), k + 1, b, p);
    end

    // Back-to-back frames and a dropped third write
    set_div(16'd3);
    wr(3'd0, 8'h01, k1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      peek(Base + 8'd1, v);
      if (v[0]) begin
        ok = 1'b1;
        break;
      end
      idle(1);
    end
    check("b2b_poll", ok, 1);
    wr(3'd0, 8'h02, k);
    peek(Base + 8'd1, v); check("b2b_not_ready", v[0], 0);
    wr(3'd0, 8'h03, k);
    idle(95);
    frame_chk("b2b_f1", k1 + 1, 8'h01, 4);
    frame_chk("b2b_f2", k1 + 41, 8'h02, 4);
    bad = 0;
    for (int i = 81; i < 95; i++) if (txd_log[k1 + i] !== 1'b1) bad++;
    check("b2b_dropped", bad, 0);

    // RX 3C with rx_avail interrupt
    wr(3'd4, 8'h01, k);
    send_rx(8'h3C, 1'b1);
    peek(Base + 8'd1, v); check("rx_status", v, exp_status());
    check("rx_irq", irq, 1);
    rd_data_chk("rx_3c");
    peek(Base + 8'd1, v); check("rx_drained", v, exp_status());
    idle(2);
    check("rx_irq_off", irq, 0);
    wr(3'd4, 8'h02, k);
    idle(2);
    check("tx_irq_on", irq, 1);
    wr(3'd4, 8'h00, k);
    idle(2);
    check("irq_off", irq, 0);

    // Five bytes unread: full and overrun
    for (int n = 0; n < 5; n++) send_rx(8'($urandom), 1'b1);
    peek(Base + 8'd1, v); check("ovr_status", v, exp_status());
    for (int n = 0; n < 5; n++) rd_data_chk($sformatf("ovr_rd%0d", n));
    rd_status_chk("ovr_clr1");
    rd_status_chk("ovr_clr2");

    // Bad stop bit, then a one-cycle glitch
    send_rx(8'($urandom), 1'b0);
    rd_status_chk("ferr_set");
    rd_status_chk("ferr_clr");
    rxd = 1'b0;
    idle(1);
    rxd = 1'b1;
    idle(20);
    peek(Base + 8'd1, v); check("glitch_status", v, exp_status());
    rd_data_chk("glitch_empty");

    // Random receive traffic with occasional bad frames and reads
    for (int n = 0; n < 10; n++) begin
      set_div(16'($urandom_range(0, 5)));
      send_rx(8'($urandom), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 1) == 1) rd_data_chk($sformatf("mix_rd%0d", n));
    end
    rd_status_chk("mix_status");
    while (mq.size() != 0) rd_data_chk("mix_drain");
    rd_data_chk("mix_empty");

    // Reset in the middle of a TX frame
    wr(3'd4, 8'h02, k);
    set_div(16'd3);
    idle(2);
    check("pre_rst_irq", irq, 1);
    wr(3'd0, 8'h00, k);
    idle(2);
    check("pre_rst_txd", txd, 0);
    rst = 1'b1;
    #1;
    check("rst_async_txd", txd, 1);
    check("rst_async_irq", irq, 0);
    #1;
    rst = 1'b0;
    idle(1);
    m_div = 16'd103; m_ovr = 1'b0; m_ferr = 1'b0; mq.delete();
    rd_status_chk("post_rst_status");
    rd(3'd2, v); check("post_rst_div_lo", v, 8'd103);
    rd(3'd3, v); check("post_rst_div_hi", v, 8'd0);
    rd(3'd4, v); check("post_rst_irq_en", v, 8'd0);
    s = cyc;
    idle(40);
    bad = 0;
    for (int i = s + 1; i <= cyc; i++) if (txd_log[i] !== 1'b1) bad++;
    check("post_rst_quiet", bad, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
